// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, stop bit.
// Bit timing is counted in 16x-baud sample ticks shared with the receiver.
module uart_tx #(
   parameter int DATA_BITS = 8,
   parameter int STOP_TICK = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_sample_tick,
   input  logic                 i_tx_start,
   input  logic [DATA_BITS-1:0] i_tx_data,
   output logic                 o_tx,
   output logic                 o_tx_busy,
   output logic                 o_tx_done_tick
);

   localparam int TW = (STOP_TICK > 16) ? 5 : 4;
   localparam int DW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [TW-1:0] BIT_LAST  = TW'(15);
   localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICK - 1);
   localparam logic [DW-1:0] DATA_LAST = DW'(DATA_BITS - 1);

   logic [1:0]           state_r, state_s;
   logic [TW-1:0]        tick_cnt_r, tick_cnt_s;
   logic [DW-1:0]        data_cnt_r, data_cnt_s;
   logic [DATA_BITS-1:0] shift_r, shift_s;
   logic                 tx_r, tx_s;
   logic                 done_s;

   // Next-state, next-line and done-strobe decode for the frame sequencer.
   always_comb begin
      state_s    = state_r;
      tick_cnt_s = tick_cnt_r;
      data_cnt_s = data_cnt_r;
      shift_s    = shift_r;
      tx_s       = tx_r;
      done_s     = 1'b0;
      case (state_r)
         S_IDLE: begin
            tx_s = 1'b1;
            if (i_tx_start) begin
               shift_s    = i_tx_data;
               tick_cnt_s = {TW{1'b0}};
               state_s    = S_START;
               tx_s       = 1'b0;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_START: begin
            if (i_sample_tick) begin
               if (tick_cnt_r == BIT_LAST) begin
                  tick_cnt_s = {TW{1'b0}};
                  data_cnt_s = {DW{1'b0}};
                  state_s    = S_DATA;
                  tx_s       = shift_r[0];
               end else begin
                  tick_cnt_s = tick_cnt_r + TW'(1);
               end
            end else begin
               tick_cnt_s = tick_cnt_r;
            end
         end
         S_DATA: begin
            if (i_sample_tick) begin
               if (tick_cnt_r == BIT_LAST) begin
                  tick_cnt_s = {TW{1'b0}};
                  shift_s    = shift_r >> 1'b1;
                  if (data_cnt_r == DATA_LAST) begin
                     state_s = S_STOP;
                     tx_s    = 1'b1;
                  end else begin
                     data_cnt_s = data_cnt_r + DW'(1);
                     // Next bit is the new LSB after the shift.
                     tx_s       = shift_s[0];
                  end
               end else begin
                  tick_cnt_s = tick_cnt_r + TW'(1);
               end
            end else begin
               tick_cnt_s = tick_cnt_r;
            end
         end
         S_STOP: begin
            tx_s = 1'b1;
            if (i_sample_tick) begin
               if (tick_cnt_r == STOP_LAST) begin
                  tick_cnt_s = {TW{1'b0}};
                  state_s    = S_IDLE;
                  done_s     = 1'b1;
               end else begin
                  tick_cnt_s = tick_cnt_r + TW'(1);
               end
            end else begin
               tick_cnt_s = tick_cnt_r;
            end
         end
         default: begin
            state_s    = S_IDLE;
            tick_cnt_s = {TW{1'b0}};
            data_cnt_s = {DW{1'b0}};
            tx_s       = 1'b1;
         end
      endcase
   end

   // Frame state registers; reset forces the line high immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         tick_cnt_r <= {TW{1'b0}};
         data_cnt_r <= {DW{1'b0}};
         shift_r    <= {DATA_BITS{1'b0}};
         tx_r       <= 1'b1;
      end else begin
         state_r    <= state_s;
         tick_cnt_r <= tick_cnt_s;
         data_cnt_r <= data_cnt_s;
         shift_r    <= shift_s;
         tx_r       <= tx_s;
      end
   end

   assign o_tx           = tx_r;
   assign o_tx_busy      = (state_r != S_IDLE);
   assign o_tx_done_tick = done_s;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: line level per sample tick is compared
// against a frame model built from bit position arithmetic.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       start16 = 1'b0;
   logic       start32 = 1'b0;
   logic [7:0] data = 8'h00;
   logic       tx16, busy16, done16, tx32, busy32, done32;

   always #5 clk = ~clk;

   uart_tx #(.DATA_BITS(8), .STOP_TICK(16)) dut (
      .clk(clk), .rst_n(rst_n), .i_sample_tick(tick), .i_tx_start(start16),
      .i_tx_data(data), .o_tx(tx16), .o_tx_busy(busy16), .o_tx_done_tick(done16));

   uart_tx #(.DATA_BITS(8), .STOP_TICK(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .i_sample_tick(tick), .i_tx_start(start32),
      .i_tx_data(data), .o_tx(tx32), .o_tx_busy(busy32), .o_tx_done_tick(done32));

   int checks = 0;
   int errors = 0;

   // Capture of one frame: line and busy sampled at every tick cycle.
   logic q_tx[$];
   logic q_busy[$];
   int   done_cnt, n_ticks, hold_bad, stray_done;
   logic start_busy, accept_tx;
   logic abort_tx, abort_busy, abort_done;

   function automatic logic cur_tx(input bit wide);
      return wide ? tx32 : tx16;
   endfunction
   function automatic logic cur_busy(input bit wide);
      return wide ? busy32 : busy16;
   endfunction
   function automatic logic cur_done(input bit wide);
      return wide ? done32 : done16;
   endfunction

   // Expected line during the j-th tick (1-based) after acceptance.
   function automatic logic exp_line(input logic [7:0] d, input int j);
      int b;
      b = (j - 1) / 16;
      if (b == 0) return 1'b0;
      else if (b <= 8) return d[b-1];
      else return 1'b1;
   endfunction

   function automatic int line_bad(input logic [7:0] d);
      int bad = 0;
      foreach (q_tx[i]) if (q_tx[i] !== exp_line(d, i + 1)) bad++;
      return bad;
   endfunction

   function automatic int busy_low();
      int n = 0;
      foreach (q_busy[i]) if (q_busy[i] !== 1'b1) n++;
      return n;
   endfunction

   // Receiver-style decode: sample each data bit in the middle of its 16 ticks.
   function automatic logic [7:0] decode();
      logic [7:0] d = 8'h00;
      for (int i = 0; i < 8; i++)
         if (16 * (i + 1) + 7 < q_tx.size()) d[i] = q_tx[16 * (i + 1) + 7];
      return d;
   endfunction

   task automatic run_frame(input logic [7:0] d, input bit wide, input bit irregular,
                            input int inject_at, input int abort_at);
      int   gap;
      logic t;
      logic held[$];
      q_tx.delete(); q_busy.delete();
      done_cnt = 0; n_ticks = 0; hold_bad = 0; stray_done = 0;
      @(negedge clk);
      tick = 1'b0; data = d;
      if (wide) start32 = 1'b1; else start16 = 1'b1;
      #1 start_busy = cur_busy(wide);
      for (int j = 1; j <= 220 && done_cnt == 0; j++) begin
         gap = irregular ? int'($urandom_range(20, 3)) : 16;
         held.delete();
         for (int k = 1; k < gap; k++) begin
            @(negedge clk);
            tick = 1'b0; start16 = 1'b0; start32 = 1'b0;
            #1;
            if (j == 1 && k == 1) accept_tx = cur_tx(wide);
            held.push_back(cur_tx(wide));
            if (cur_done(wide)) stray_done++;
         end
         @(negedge clk);
         if (j == abort_at) begin
            tick = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            abort_tx = cur_tx(wide); abort_busy = cur_busy(wide); abort_done = cur_done(wide);
            return;
         end
         tick = 1'b1;
         if (j == inject_at) begin
            start16 = !wide; start32 = wide; data = 8'h3C;
         end
         #1;
         t = cur_tx(wide);
         q_tx.push_back(t);
         q_busy.push_back(cur_busy(wide));
         n_ticks++;
         foreach (held[i]) if (held[i] !== t) hold_bad++;
         if (cur_done(wide)) done_cnt++;
      end
   endtask

   task automatic idle_observe(input int n, input bit wide,
                               output int busy_seen, output int done_seen, output int low_seen);
      busy_seen = 0; done_seen = 0; low_seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick = (i % 4 == 3); start16 = 1'b0; start32 = 1'b0;
         #1;
         if (cur_busy(wide)) busy_seen++;
         if (cur_done(wide)) done_seen++;
         if (!cur_tx(wide)) low_seen++;
      end
   endtask

   task automatic test_reset();
      int b, dn, lo;
      rst_n = 1'b0; start16 = 1'b1; start32 = 1'b1; data = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); tick = i[0];
      end
      #1;
      checks++; if (tx16 !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", tx16); end
      checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy16); end
      checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done16); end
      checks++; if (tx32 !== 1'b1 || busy32 !== 1'b0) begin errors++; $display("FAIL rst_dut32: tx %b busy %b expected 1 0", tx32, busy32); end
      @(negedge clk);
      rst_n = 1'b1; start16 = 1'b0; start32 = 1'b0; tick = 1'b0;
      idle_observe(40, 1'b0, b, dn, lo);
      checks++; if (lo !== 0 || b !== 0 || dn !== 0) begin errors++; $display("FAIL rst_release_idle: low %0d busy %0d done %0d expected 0 0 0", lo, b, dn); end
   endtask

   task automatic test_a5();
      int b, dn, lo, bad;
      run_frame(8'hA5, 1'b0, 1'b0, 0, 0);
      bad = line_bad(8'hA5);
      checks++; if (start_busy !== 1'b0) begin errors++; $display("FAIL a5_idle_before: busy %b expected 0", start_busy); end
      checks++; if (accept_tx !== 1'b0) begin errors++; $display("FAIL a5_start_latency: tx %b expected 0", accept_tx); end
      checks++; if (n_ticks !== 160) begin errors++; $display("FAIL a5_frame_ticks: got %0d expected 160", n_ticks); end
      checks++; if (done_cnt !== 1 || stray_done !== 0) begin errors++; $display("FAIL a5_done: got %0d stray %0d expected 1 0", done_cnt, stray_done); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL a5_line: %0d wrong ticks expected 0", bad); end
      checks++; if (busy_low() !== 0) begin errors++; $display("FAIL a5_busy: low on %0d ticks expected 0", busy_low()); end
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL a5_hold: %0d changes between ticks expected 0", hold_bad); end
      idle_observe(40, 1'b0, b, dn, lo);
      checks++; if (b !== 0 || dn !== 0 || lo !== 0) begin errors++; $display("FAIL a5_after: busy %0d done %0d low %0d expected 0 0 0", b, dn, lo); end
   endtask

   task automatic test_random();
      logic [7:0] d;
      bit         irr;
      for (int f = 0; f < 3; f++) begin
         d = 8'($urandom);
         irr = 1'($urandom);
         run_frame(d, 1'b0, irr, 0, 0);
         checks++; if (line_bad(d) !== 0 || n_ticks !== 160) begin errors++; $display("FAIL rand_line: data %h bad %0d ticks %0d expected 0 160", d, line_bad(d), n_ticks); end
         checks++; if (done_cnt !== 1 || hold_bad !== 0) begin errors++; $display("FAIL rand_done_hold: data %h done %0d hold %0d expected 1 0", d, done_cnt, hold_bad); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d1;
      int         n1, dc1;
      run_frame(8'h00, 1'b0, 1'b0, 0, 0);
      d1 = decode(); n1 = n_ticks; dc1 = done_cnt;
      run_frame(8'hFF, 1'b0, 1'b0, 0, 0);
      checks++; if (d1 !== 8'h00 || n1 !== 160 || dc1 !== 1) begin errors++; $display("FAIL b2b_first: data %h ticks %0d done %0d expected 00 160 1", d1, n1, dc1); end
      checks++; if (start_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after_done: busy %b expected 0", start_busy); end
      checks++; if (accept_tx !== 1'b0) begin errors++; $display("FAIL b2b_immediate_start: tx %b expected 0", accept_tx); end
      checks++; if (decode() !== 8'hFF || line_bad(8'hFF) !== 0) begin errors++; $display("FAIL b2b_second: data %h bad %0d expected ff 0", decode(), line_bad(8'hFF)); end
      checks++; if (done_cnt !== 1 || n_ticks !== 160) begin errors++; $display("FAIL b2b_second_done: done %0d ticks %0d expected 1 160", done_cnt, n_ticks); end
   endtask

   task automatic test_ignore_midframe();
      logic [7:0] d;
      int         b, dn, lo;
      d = 8'($urandom) ^ 8'h81;
      if (d == 8'h3C) d = 8'hC3;
      run_frame(d, 1'b0, 1'b0, 50, 0);
      checks++; if (line_bad(d) !== 0 || decode() !== d) begin errors++; $display("FAIL mid_start_line: data %h got %h bad %0d", d, decode(), line_bad(d)); end
      checks++; if (done_cnt !== 1 || n_ticks !== 160) begin errors++; $display("FAIL mid_start_done: done %0d ticks %0d expected 1 160", done_cnt, n_ticks); end
      idle_observe(60, 1'b0, b, dn, lo);
      checks++; if (b !== 0 || lo !== 0 || dn !== 0) begin errors++; $display("FAIL mid_start_queued: busy %0d low %0d done %0d expected 0 0 0", b, lo, dn); end
   endtask

   task automatic test_reset_midframe();
      int b, dn, lo;
      run_frame(8'h37, 1'b0, 1'b0, 0, 70);
      checks++; if (q_tx.size() != 69 || q_tx[68] !== 1'b0) begin errors++; $display("FAIL rstmid_pre_line: ticks %0d expected 69 with line low", q_tx.size()); end
      checks++; if (abort_tx !== 1'b1 || abort_busy !== 1'b0 || abort_done !== 1'b0) begin errors++; $display("FAIL rstmid_async: tx %b busy %b done %b expected 1 0 0", abort_tx, abort_busy, abort_done); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle_observe(40, 1'b0, b, dn, lo);
      checks++; if (b !== 0 || lo !== 0 || dn !== 0) begin errors++; $display("FAIL rstmid_no_resume: busy %0d low %0d done %0d expected 0 0 0", b, lo, dn); end
      run_frame(8'h81, 1'b0, 1'b0, 0, 0);
      checks++; if (line_bad(8'h81) !== 0 || decode() !== 8'h81 || done_cnt !== 1) begin errors++; $display("FAIL rstmid_new_frame: got %h bad %0d done %0d expected 81 0 1", decode(), line_bad(8'h81), done_cnt); end
   endtask

   task automatic test_stop32();
      logic [7:0] d;
      for (int f = 0; f < 2; f++) begin
         d = 8'($urandom);
         run_frame(d, 1'b1, 1'b1, 0, 0);
         checks++; if (n_ticks !== 176 || done_cnt !== 1) begin errors++; $display("FAIL stop32_len: ticks %0d done %0d expected 176 1", n_ticks, done_cnt); end
         checks++; if (line_bad(d) !== 0 || hold_bad !== 0) begin errors++; $display("FAIL stop32_line: data %h bad %0d hold %0d expected 0 0", d, line_bad(d), hold_bad); end
         checks++; if (busy_low() !== 0 || stray_done !== 0) begin errors++; $display("FAIL stop32_busy: low %0d stray %0d expected 0 0", busy_low(), stray_done); end
      end
   endtask

   initial begin
      test_reset();
      test_a5();
      test_random();
      test_back_to_back();
      test_ignore_midframe();
      test_reset_midframe();
      test_stop32();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
